or1200_ic_biu: RTL and testbench

- Instruction-side bus interface unit: the responder end of the IC FSM read interface (`biu_read`/`burst`/address in; `biudata_valid`/`biudata_error`/data out).
- Converts each cache read request into a Wishbone B3 read cycle:
  - single classic beat for uncached or hit-transient fetches;
  - 4-beat wrapping burst for line refills.
- Sits between the IC top level and the external instruction Wishbone master port.

---
 rtl/or1200_ic_biu_pkg.sv | 20 ++
 rtl/or1200_ic_biu_addrgen.sv | 45 ++++
 rtl/or1200_ic_biu.sv | 151 +++++++++++++++
 tb/tb_or1200_ic_biu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_ic_biu_pkg.sv
// Shared types and Wishbone B3 encodings for the instruction-side bus interface unit.
package or1200_ic_biu_pkg;

  localparam int LINE_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_GAP
  } biu_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;

endpackage

// File: rtl/or1200_ic_biu_addrgen.sv
// Beat address and beat counter for line refills; the low word-address bits wrap
// within the line so the critical word goes out first.
module or1200_ic_biu_addrgen
  import or1200_ic_biu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [29:0] load_addr_i,
  input  logic        load_burst_i,
  input  logic        advance_i,
  output logic [31:0] adr_o,
  output logic        burst_o,
  output logic        last_o,
  output logic        to_last_o
);

  localparam int CW = $clog2(LINE_BEATS);

  logic [29:0]   adr_q;
  logic [CW-1:0] cnt_q;
  logic          burst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q   <= '0;
      cnt_q   <= '0;
      burst_q <= 1'b0;
    end else if (load_i) begin
      adr_q   <= load_addr_i;
      cnt_q   <= '0;
      burst_q <= load_burst_i;
    end else if (advance_i) begin
      adr_q[CW-1:0] <= adr_q[CW-1:0] + 1'b1;
      cnt_q         <= cnt_q + 1'b1;
    end
  end

  assign adr_o     = {adr_q, 2'b00};
  assign burst_o   = burst_q;
  assign last_o    = !burst_q || (cnt_q == CW'(LINE_BEATS - 1));
  // Beat whose acknowledge moves the burst onto its final beat.
  assign to_last_o = burst_q && (cnt_q == CW'(LINE_BEATS - 2));

endmodule

// File: rtl/or1200_ic_biu.sv
// Instruction-cache bus interface: turns IC read requests into Wishbone B3 classic
// single reads or wrap-4 line bursts, with retry limiting and abort draining.
module or1200_ic_biu
  import or1200_ic_biu_pkg::*;
#(
  parameter int RTY_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        biu_read,
  input  logic        biu_burst,
  input  logic [31:0] biu_addr,
  output logic [31:0] biudata_o,
  output logic        biudata_valid,
  output logic        biudata_error,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  biu_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  cti_q, cti_d;
  logic [1:0]  bte_q, bte_d;
  logic [3:0]  rty_cnt_q, rty_cnt_d;

  logic        load, advance;
  logic        ag_burst, ag_last, ag_to_last;
  logic [31:0] ag_adr;
  logic        in_cycle, ack, err, rty, rty_hit, beat_err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^biu_addr[1:0];

  or1200_ic_biu_addrgen u_addrgen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_addr_i  (biu_addr[31:2]),
    .load_burst_i (biu_burst),
    .advance_i    (advance),
    .adr_o        (ag_adr),
    .burst_o      (ag_burst),
    .last_o       (ag_last),
    .to_last_o    (ag_to_last)
  );

  // Terminations are only meaningful while a cycle is open; err outranks ack outranks rty.
  assign in_cycle = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign err      = in_cycle && wb_err_i;
  assign ack      = in_cycle && wb_ack_i && !wb_err_i;
  assign rty      = in_cycle && wb_rty_i && !wb_ack_i && !wb_err_i;
  assign rty_hit  = rty && (rty_cnt_q == 4'(RTY_MAX - 1));
  assign beat_err = err || rty_hit;

  assign biudata_o     = wb_dat_i;
  assign biudata_valid = (state_q == ST_ACTIVE) && ack && biu_read;
  assign biudata_error = (state_q == ST_ACTIVE) && beat_err && biu_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      cti_q     <= CTI_CLASSIC;
      bte_q     <= BTE_LINEAR;
      rty_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cti_q     <= cti_d;
      bte_q     <= bte_d;
      rty_cnt_q <= rty_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cti_d     = cti_q;
    bte_d     = bte_q;
    rty_cnt_d = rty_cnt_q;
    load      = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (biu_read) begin
          load      = 1'b1;
          cyc_d     = 1'b1;
          cti_d     = biu_burst ? CTI_INCR : CTI_CLASSIC;
          bte_d     = biu_burst ? BTE_WRAP4 : BTE_LINEAR;
          rty_cnt_d = '0;
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (beat_err || (ack && ag_last)) begin
          state_d   = ST_GAP;
          cyc_d     = 1'b0;
          cti_d     = CTI_CLASSIC;
          bte_d     = BTE_LINEAR;
          rty_cnt_d = '0;
        end else if (ack) begin
          advance   = 1'b1;
          rty_cnt_d = '0;
          if (!biu_read) begin
            cti_d   = CTI_EOB;
            state_d = ST_DRAIN;
          end else if (ag_to_last) begin
            cti_d   = CTI_EOB;
          end
        end else begin
          if (rty) rty_cnt_d = rty_cnt_q + 1'b1;
          if (!biu_read) begin
            state_d = ST_DRAIN;
            if (ag_burst) cti_d = CTI_EOB;
          end
        end
      end
      ST_DRAIN: begin
        if (beat_err || ack) begin
          state_d   = ST_GAP;
          cyc_d     = 1'b0;
          cti_d     = CTI_CLASSIC;
          bte_d     = BTE_LINEAR;
          rty_cnt_d = '0;
        end else if (rty) begin
          rty_cnt_d = rty_cnt_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_adr_o = ag_adr;
  assign wb_cti_o = cti_q;
  assign wb_bte_o = bte_q;

endmodule

// File: tb/tb_or1200_ic_biu.sv
// Directed bench for or1200_ic_biu: stimulus pushes expected IC responses into a queue,
// a negedge monitor pops and compares them whenever valid or error is presented.
module tb_or1200_ic_biu;

  logic        clk = 1'b0;
  logic        rst;
  logic        biu_read, biu_burst;
  logic [31:0] biu_addr;
  logic [31:0] biudata_o;
  logic        biudata_valid, biudata_error;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  or1200_ic_biu dut (
    .clk           (clk),
    .rst           (rst),
    .biu_read      (biu_read),
    .biu_burst     (biu_burst),
    .biu_addr      (biu_addr),
    .biudata_o     (biudata_o),
    .biudata_valid (biudata_valid),
    .biudata_error (biudata_error),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_adr_o      (wb_adr_o),
    .wb_cti_o      (wb_cti_o),
    .wb_bte_o      (wb_bte_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_rty_i      (wb_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit is_err, logic [31:0] data);
    resp_t r;
    r.is_err = is_err;
    r.data   = data;
    exp_q.push_back(r);
  endtask

  task automatic bus(string name, logic cyc, logic [31:0] adr, logic [2:0] cti, logic [1:0] bte);
    chk({name, " cyc"}, {31'b0, wb_cyc_o}, {31'b0, cyc});
    chk({name, " stb"}, {31'b0, wb_stb_o}, {31'b0, cyc});
    chk({name, " sel"}, {28'b0, wb_sel_o}, cyc ? 32'hF : 32'h0);
    if (cyc) begin
      chk({name, " adr"}, wb_adr_o, adr);
      chk({name, " cti"}, {29'b0, wb_cti_o}, {29'b0, cti});
      chk({name, " bte"}, {30'b0, wb_bte_o}, {30'b0, bte});
    end
  endtask

  task automatic check_zero(string name);
    chk({name, " cyc"}, {31'b0, wb_cyc_o}, 32'h0);
    chk({name, " stb"}, {31'b0, wb_stb_o}, 32'h0);
    chk({name, " sel"}, {28'b0, wb_sel_o}, 32'h0);
    chk({name, " adr"}, wb_adr_o, 32'h0);
    chk({name, " cti"}, {29'b0, wb_cti_o}, 32'h0);
    chk({name, " bte"}, {30'b0, wb_bte_o}, 32'h0);
    chk({name, " we"},  {31'b0, wb_we_o}, 32'h0);
    chk({name, " valid"}, {31'b0, biudata_valid}, 32'h0);
    chk({name, " error"}, {31'b0, biudata_error}, 32'h0);
  endtask

  task automatic expect_drained(string name);
    chk({name, " pending responses"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic request(logic burst, logic [31:0] addr);
    biu_read  = 1'b1;
    biu_burst = burst;
    biu_addr  = addr;
    tick();
  endtask

  initial begin
    logic [31:0] adr_tab[4];
    logic [2:0]  cti_tab[4];

    fork
      begin : monitor
        resp_t r;
        forever begin
          @(negedge clk);
          if (rst && (biudata_valid || biudata_error)) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_response: valid=%0b error=%0b data=%08h, none required",
                       biudata_valid, biudata_error, biudata_o);
            end else begin
              r = exp_q.pop_front();
              chk("resp_kind", {30'b0, biudata_error, biudata_valid}, r.is_err ? 32'h2 : 32'h1);
              if (!r.is_err) chk("resp_data", biudata_o, r.data);
              $display("txn t=%0t valid=%0b error=%0b data=%08h", $time, biudata_valid,
                       biudata_error, biudata_o);
            end
          end
        end
      end
    join_none

    rst = 1'b0; biu_read = 1'b0; biu_burst = 1'b0; biu_addr = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    #12;
    check_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // Single read with two wait states.
    request(1'b0, 32'h1000_0104);
    bus("single w0", 1'b1, 32'h1000_0104, 3'b000, 2'b00);
    tick();
    bus("single w1", 1'b1, 32'h1000_0104, 3'b000, 2'b00);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; push(1'b0, 32'hDEAD_BEEF);
    tick();
    wb_ack_i = 1'b0; biu_read = 1'b0;
    bus("single gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    bus("single idle", 1'b0, 32'h0, 3'b000, 2'b00);
    expect_drained("single");

    // Wrap-4 burst from the third word; address/burst changes after acceptance ignored.
    adr_tab[0] = 32'h2000_0008; adr_tab[1] = 32'h2000_000C;
    adr_tab[2] = 32'h2000_0000; adr_tab[3] = 32'h2000_0004;
    cti_tab[0] = 3'b010; cti_tab[1] = 3'b010; cti_tab[2] = 3'b010; cti_tab[3] = 3'b111;
    request(1'b1, 32'h2000_0008);
    biu_addr = 32'hFFFF_FFF0; biu_burst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus($sformatf("burst beat%0d", i), 1'b1, adr_tab[i], cti_tab[i], 2'b01);
      wb_ack_i = 1'b1; wb_dat_i = 32'hB000_0000 + 32'(i); push(1'b0, 32'hB000_0000 + 32'(i));
      tick();
    end
    wb_ack_i = 1'b0; biu_read = 1'b0;
    bus("burst gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("burst");

    // Error on beat 2 abandons the burst.
    request(1'b1, 32'h3000_0000);
    wb_ack_i = 1'b1; wb_dat_i = 32'h3000_00A0; push(1'b0, 32'h3000_00A0);
    tick();
    wb_dat_i = 32'h3000_00A1; push(1'b0, 32'h3000_00A1);
    tick();
    bus("err beat2", 1'b1, 32'h3000_0008, 3'b010, 2'b01);
    wb_ack_i = 1'b0; wb_err_i = 1'b1; push(1'b1, 32'h0);
    tick();
    wb_err_i = 1'b0; biu_read = 1'b0;
    bus("err gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    bus("err idle", 1'b0, 32'h0, 3'b000, 2'b00);
    expect_drained("err burst");

    // ack and err together: err wins.
    request(1'b0, 32'h3000_1000);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1111_1111; push(1'b1, 32'h0);
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; biu_read = 1'b0;
    bus("ackerr gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("ack+err");

    // Abort while beat 1 waits: data swallowed in DRAIN, cti switched to end-of-burst.
    request(1'b1, 32'h4000_0010);
    wb_ack_i = 1'b1; wb_dat_i = 32'h4444_0000; push(1'b0, 32'h4444_0000);
    tick();
    wb_ack_i = 1'b0;
    bus("abort beat1", 1'b1, 32'h4000_0014, 3'b010, 2'b01);
    tick();
    biu_read = 1'b0;
    tick();
    bus("abort drain", 1'b1, 32'h4000_0014, 3'b111, 2'b01);
    tick();
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h4444_0001;
    tick();
    wb_ack_i = 1'b0;
    bus("abort gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("abort");

    // biu_read drop coincident with ack of a non-last beat: no valid, then drain.
    request(1'b1, 32'h4000_0020);
    biu_read = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h4444_0002;
    tick();
    wb_ack_i = 1'b0;
    bus("dropack drain", 1'b1, 32'h4000_0024, 3'b111, 2'b01);
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    bus("dropack gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("drop+ack");

    // Three retries, then ack: same beat re-presented, one valid.
    request(1'b0, 32'h5000_0040);
    wb_rty_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus($sformatf("retry%0d", i), 1'b1, 32'h5000_0040, 3'b000, 2'b00);
      tick();
    end
    wb_rty_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678; push(1'b0, 32'h1234_5678);
    tick();
    wb_ack_i = 1'b0; biu_read = 1'b0;
    bus("retry gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("retry");

    // Fifteen consecutive retries: the fifteenth is reported as an error.
    request(1'b0, 32'h6000_0000);
    wb_rty_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus($sformatf("rtylim%0d", i), 1'b1, 32'h6000_0000, 3'b000, 2'b00);
      if (i == 14) push(1'b1, 32'h0);
      tick();
    end
    wb_rty_i = 1'b0; biu_read = 1'b0;
    bus("rtylim gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("retry limit");

    // Asynchronous reset mid-burst, then a clean fresh transaction.
    request(1'b1, 32'h7000_0004);
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_0000; push(1'b0, 32'h7777_0000);
    tick();
    wb_ack_i = 1'b0;
    bus("prereset beat1", 1'b1, 32'h7000_0008, 3'b010, 2'b01);
    #1 rst = 1'b0;
    #1 check_zero("async reset");
    wb_ack_i = 1'b1;
    #1 check_zero("reset with ack");
    wb_ack_i = 1'b0; biu_read = 1'b0;
    expect_drained("pre-reset");
    tick();
    rst = 1'b1;
    tick();
    request(1'b0, 32'h7000_0100);
    bus("post-reset", 1'b1, 32'h7000_0100, 3'b000, 2'b00);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; push(1'b0, 32'hCAFE_F00D);
    tick();
    wb_ack_i = 1'b0; biu_read = 1'b0;
    bus("post-reset gap", 1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    expect_drained("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
